sha256_digest_serializer: RTL and testbench

Downstream stage of the sha256 top. It captures the 256-bit digest on the single-cycle hash_valid pulse and streams it out as bytes over a valid/ready handshake, either raw or as lowercase ASCII hex. It also compares the captured digest against an expected value and flags overruns. It sits between the sha256 hash_out/hash_valid outputs and a byte-wide sink such as a UART TX or FIFO.

---
 rtl/sha256_pkg.sv | 18 +
 rtl/sha256_digest_serializer_nibble_to_hex.sv | 12 +
 rtl/sha256_digest_serializer.sv | 108 ++++++++++
 tb/tb_sha256_digest_serializer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and helpers for the sha256 digest path.
// Digest width, serializer FSM states and nibble-to-ASCII mapping.
package sha256_pkg;

  localparam int DIGEST_BITS = 256;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FLUSH
  } state_e;

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    if (n < 4'd10) nib2hex = 8'h30 + {4'h0, n};
    else           nib2hex = 8'h57 + {4'h0, n};
  endfunction

endpackage

// File: rtl/sha256_digest_serializer_nibble_to_hex.sv
// Combinational 4-bit to lowercase ASCII hex encoder.
// Used by the serializer only in hex output mode.
module nibble_to_hex
  import sha256_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] hex_o
);

  assign hex_o = nib2hex(nib_i);

endmodule

// File: rtl/sha256_digest_serializer.sv
// Captures a sha256 digest and streams it out bytewise (raw or hex),
// with an optional match check and a sticky overrun flag.
module sha256_digest_serializer #(
  parameter int DIGEST_BITS = sha256_pkg::DIGEST_BITS,
  parameter bit ASCII_HEX   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DIGEST_BITS-1:0] hash_in,
  input  logic                   hash_valid,
  input  logic                   compare_en,
  input  logic [DIGEST_BITS-1:0] expected_digest,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   match,
  output logic                   match_valid,
  output logic                   overrun
);

  import sha256_pkg::*;

  localparam int BEATS = ASCII_HEX ? DIGEST_BITS / 4
                                   : DIGEST_BITS / 8;
  localparam int CW    = $clog2(BEATS);
  localparam int SHIFT = ASCII_HEX ? 4 : 8;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  state_e                 state_q, state_d;
  logic [DIGEST_BITS-1:0] sh_q, sh_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   match_q, match_d;
  logic                   mv_q, mv_d;
  logic                   ovr_q, ovr_d;
  logic [7:0]             top_byte;

  if (ASCII_HEX) begin : gen_hex
    nibble_to_hex u_hex (
      .nib_i (sh_q[DIGEST_BITS-1 -: 4]),
      .hex_o (top_byte)
    );
  end else begin : gen_raw
    assign top_byte = sh_q[DIGEST_BITS-1 -: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      mv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      mv_q    <= mv_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    mv_d    = 1'b0;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (hash_valid) begin
          sh_d    = hash_in;
          match_d = compare_en && (hash_in == expected_digest);
          mv_d    = compare_en;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hash_valid) ovr_d = 1'b1;
        if (out_ready) begin
          sh_d = sh_q << SHIFT;
          if (cnt_q == LAST) state_d = FLUSH;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        // busy still covers this cycle, so a new digest is dropped
        if (hash_valid) ovr_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid   = (state_q == SEND);
  assign out_data    = out_valid ? top_byte : 8'h00;
  assign out_last    = out_valid && (cnt_q == LAST);
  assign busy        = (state_q != IDLE);
  assign match       = match_q;
  assign match_valid = mv_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Bench: raw and hex serializers side by side, table vectors plus
// random backpressure against a byte/char list model of the digest.
module tb_sha256_digest_serializer;

  localparam logic [255:0] ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] hash_in;
  logic         hash_valid;
  logic         compare_en;
  logic [255:0] expected_digest;
  logic         out_ready;

  logic [7:0] od[2];
  logic       ov[2], ol[2], bz[2], mt[2], mv[2], orun[2];

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] expb[2][64];
  int         nbeats[2];

  always #5 clk = ~clk;

  sha256_digest_serializer #(.DIGEST_BITS(256), .ASCII_HEX(1'b0)) u_raw (
    .clk(clk), .rst_n(rst_n), .hash_in(hash_in), .hash_valid(hash_valid),
    .compare_en(compare_en), .expected_digest(expected_digest),
    .out_data(od[0]), .out_valid(ov[0]), .out_last(ol[0]),
    .out_ready(out_ready), .busy(bz[0]), .match(mt[0]),
    .match_valid(mv[0]), .overrun(orun[0])
  );

  sha256_digest_serializer #(.DIGEST_BITS(256), .ASCII_HEX(1'b1)) u_hex (
    .clk(clk), .rst_n(rst_n), .hash_in(hash_in), .hash_valid(hash_valid),
    .compare_en(compare_en), .expected_digest(expected_digest),
    .out_data(od[1]), .out_valid(ov[1]), .out_last(ol[1]),
    .out_ready(out_ready), .busy(bz[1]), .match(mt[1]),
    .match_valid(mv[1]), .overrun(orun[1])
  );

  typedef struct {
    logic [255:0] digest;
    logic [255:0] expd;
    bit           cmp;
    bit           exp_match;
    bit           exp_mv;
    int           pct;
    int           inj;
    bit           exp_ovr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [255:0] a,
                     input logic [255:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic build_model(input logic [255:0] d);
    string hexs = "0123456789abcdef";
    logic [3:0] nib;
    nbeats[0] = 32;
    nbeats[1] = 64;
    for (int i = 0; i < 32; i++) expb[0][i] = d[255-8*i -: 8];
    for (int i = 0; i < 64; i++) begin
      nib = d[255-4*i -: 4];
      expb[1][i] = hexs[int'(nib)];
    end
  endtask

  task automatic capture(input vec_t v);
    hash_in         = v.digest;
    expected_digest = v.expd;
    compare_en      = v.cmp;
    hash_valid      = 1'b1;
    @(negedge clk);
    hash_valid = 1'b0;
    compare_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("match", mt[k], v.exp_match);
      chk("match_valid", mv[k], v.exp_mv);
      chk("busy_on_capture", bz[k], 1);
      chk("valid_after_capture", ov[k], 1);
    end
  endtask

  task automatic stream(input logic [255:0] d, input int pct,
                        input int inj);
    int         idx[2];
    int         post[2];
    logic       stall[2];
    logic [7:0] hd[2];
    logic       hl[2];
    logic       rdy;
    int         cyc;
    build_model(d);
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      idx[k] = 0; post[k] = -1; stall[k] = 1'b0;
      hd[k] = 8'h00; hl[k] = 1'b0;
    end
    while (!(post[0] >= 2 && post[1] >= 2) && cyc < 3000) begin
      rdy        = ($urandom_range(99) < pct);
      out_ready  = rdy;
      hash_valid = (inj >= 0 && idx[0] == inj && ov[0] && rdy);
      hash_in    = {8{$urandom}};
      for (int k = 0; k < 2; k++) begin
        if (cyc == 1) chk("match_valid_one_cycle", mv[k], 0);
        if (stall[k]) begin
          chk("stall_valid", ov[k], 1);
          chk("stall_data", od[k], hd[k]);
          chk("stall_last", ol[k], hl[k]);
        end
        if (post[k] >= 0) begin
          post[k]++;
          stall[k] = 1'b0;
          if (post[k] == 1) chk("busy_in_flush", bz[k], 1);
          if (post[k] == 2) chk("busy_after_flush", bz[k], 0);
          if (post[k] <= 3) chk("no_second_stream", ov[k], 0);
        end else if (ov[k]) begin
          stall[k] = !rdy;
          hd[k]    = od[k];
          hl[k]    = ol[k];
          if (rdy) begin
            if (idx[k] >= nbeats[k]) begin
              chk("extra_beat", idx[k], nbeats[k] - 1);
            end else begin
              chk("beat_data", od[k], expb[k][idx[k]]);
              chk("beat_last", ol[k], idx[k] == nbeats[k] - 1);
              idx[k]++;
              if (idx[k] == nbeats[k]) post[k] = 0;
            end
          end
        end else begin
          chk("valid_dropped_midstream", ov[k], 1);
        end
      end
      @(negedge clk);
      cyc++;
    end
    hash_valid = 1'b0;
    out_ready  = 1'b0;
    if (cyc >= 3000) chk("stream_timeout", cyc, 0);
    chk("raw_beat_count", idx[0], 32);
    chk("hex_beat_count", idx[1], 64);
  endtask

  initial begin
    rst_n           = 1'b0;
    hash_in         = '0;
    hash_valid      = 1'b0;
    compare_en      = 1'b0;
    expected_digest = '0;
    out_ready       = 1'b0;

    vecs[0] = '{ABC, '0, 1'b0, 1'b0, 1'b0, 100, -1, 1'b0};
    vecs[1] = '{ABC, ABC, 1'b1, 1'b1, 1'b1, 50, -1, 1'b0};
    vecs[2] = '{ABC, ABC ^ 256'd1, 1'b1, 1'b0, 1'b1, 100, 10, 1'b1};
    vecs[3].digest = {8{$urandom}};
    vecs[3] = '{vecs[3].digest, vecs[3].digest, 1'b1, 1'b1, 1'b1,
                100, 31, 1'b1};
    vecs[4].digest = {8{$urandom}};
    vecs[4] = '{vecs[4].digest, vecs[4].digest, 1'b0, 1'b0, 1'b0,
                70, -1, 1'b1};

    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_data", od[k], 0);
      chk("rst_out_valid", ov[k], 0);
      chk("rst_out_last", ol[k], 0);
      chk("rst_busy", bz[k], 0);
      chk("rst_match", mt[k], 0);
      chk("rst_match_valid", mv[k], 0);
      chk("rst_overrun", orun[k], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      capture(vecs[i]);
      stream(vecs[i].digest, vecs[i].pct, vecs[i].inj);
      for (int k = 0; k < 2; k++) begin
        chk("overrun_after", orun[k], vecs[i].exp_ovr);
        chk("match_held", mt[k], vecs[i].exp_match);
      end
      @(negedge clk);
    end

    capture(vecs[0]);
    out_ready = 1'b0;
    repeat (8) begin
      chk("hold_raw", od[0], 8'hba);
      chk("hold_hex", od[1], 8'h62);
      chk("hold_valid", ov[0] & ov[1], 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    out_ready = 1'b0;
    chk("beat5_raw", od[0], 8'h01);
    chk("beat5_hex", od[1], 8'h36);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("abort_valid", ov[k], 0);
      chk("abort_busy", bz[k], 0);
      chk("abort_overrun", orun[k], 0);
      chk("abort_data", od[k], 0);
      chk("abort_last", ol[k], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    capture(vecs[0]);
    stream(ABC, 100, -1);
    for (int k = 0; k < 2; k++) chk("overrun_after_reset", orun[k], 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
